// File: rtl/sd_cmd_seq.sv
// SD-card SPI-mode transaction sequencer driving a byte-level SPI master's register strobes.
// Build with SD_CRC16_CHECK_EN defined to verify the data block CRC16 and report crc_err.
module sd_cmd_seq #(
  parameter int XFER_WAIT   = 18,
  parameter int INIT_WAIT   = 22600,
  parameter int R1_TRIES    = 8,
  parameter int TOKEN_TRIES = 4096
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_start,
  input  logic [5:0]  cmd_index,
  input  logic [31:0] cmd_arg,
  input  logic [6:0]  cmd_crc,
  input  logic        cmd_data,
  output logic        busy,
  output logic        done,
  output logic [7:0]  r1,
  output logic        err_timeout,
  output logic        err_token,
  output logic        crc_err,
  output logic        data_valid,
  output logic [8:0]  data_addr,
  output logic [7:0]  data_byte,
  output logic        spi_enable,
  output logic        spi_rnw,
  output logic [2:0]  spi_addr,
  output logic [7:0]  spi_din,
  input  logic [7:0]  spi_dout
);
  localparam int CW = $clog2(INIT_WAIT + XFER_WAIT + 1);
  localparam int TW = $clog2(TOKEN_TRIES + R1_TRIES + 1);

  typedef enum logic [3:0] {
    S_INIT, S_IDLE, S_CSLO, S_SEND, S_POLL_R1, S_TOKEN, S_DATA, S_CRC, S_CSHI, S_FLUSH, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] try_q, try_d;
  logic          wait_q, wait_d;
  logic [5:0]    idx_q, idx_d;
  logic [31:0]   arg_q, arg_d;
  logic [6:0]    crc7_q, crc7_d;
  logic          data_q, data_d;
  logic [7:0]    r1_q, r1_d;
  logic          tmo_q, tmo_d, tok_q, tok_d;
  logic          dv_q, dv_d;
  logic [8:0]    daddr_q, daddr_d;
  logic [7:0]    dbyte_q, dbyte_d;
  logic          en_q, en_d, rnw_q, rnw_d;
  logic [2:0]    addr_q, addr_d;
  logic [7:0]    din_q, din_d;

  logic          in_op, is_cs, op_done;
  logic [2:0]    op_addr;
  logic [7:0]    op_din;
  logic [CW-1:0] op_limit;

  assign in_op    = state_q inside {S_CSLO, S_SEND, S_POLL_R1, S_TOKEN, S_DATA, S_CRC, S_CSHI, S_FLUSH};
  assign is_cs    = (state_q == S_CSLO) || (state_q == S_CSHI);
  assign op_limit = is_cs ? CW'(2) : CW'(XFER_WAIT);
  assign op_done  = in_op && wait_q && (cnt_q == op_limit);

  always_comb begin
    op_addr = 3'd1;
    op_din  = 8'hFF;
    case (state_q)
      S_CSLO: op_addr = 3'd4;
      S_CSHI: op_addr = 3'd3;
      S_SEND: begin
        op_addr = 3'd0;
        case (try_q[2:0])
          3'd0:    op_din = {2'b01, idx_q};
          3'd1:    op_din = arg_q[31:24];
          3'd2:    op_din = arg_q[23:16];
          3'd3:    op_din = arg_q[15:8];
          3'd4:    op_din = arg_q[7:0];
          default: op_din = {crc7_q, 1'b1};
        endcase
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q; cnt_d = cnt_q; try_d = try_q; wait_d = wait_q;
    idx_d = idx_q; arg_d = arg_q; crc7_d = crc7_q; data_d = data_q;
    r1_d = r1_q; tmo_d = tmo_q; tok_d = tok_q;
    dv_d = 1'b0; daddr_d = daddr_q; dbyte_d = dbyte_q;
    en_d = 1'b0; rnw_d = rnw_q; addr_d = addr_q; din_d = din_q;
    // Index advances the cycle after its strobe so data_addr matches data_byte while valid.
    if (dv_q) daddr_d = daddr_q + 9'd1;
    case (state_q)
      S_INIT: begin
        if (cnt_q == CW'(INIT_WAIT - 1)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_IDLE: begin
        if (cmd_start) begin
          idx_d = cmd_index; arg_d = cmd_arg; crc7_d = cmd_crc; data_d = cmd_data;
          tmo_d = 1'b0; tok_d = 1'b0; wait_d = 1'b0; try_d = '0;
          state_d = S_CSLO;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: begin
        if (!wait_q) begin
          en_d = 1'b1; rnw_d = 1'b0; addr_d = op_addr;
          if (op_addr == 3'd0) din_d = op_din;
          wait_d = 1'b1;
          cnt_d  = '0;
        end else if (!op_done) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          wait_d = 1'b0;
          try_d  = try_q + 1'b1;
          case (state_q)
            S_CSLO: begin state_d = S_SEND; try_d = '0; end
            S_SEND: if (try_q == TW'(5)) begin state_d = S_POLL_R1; try_d = '0; end
            S_POLL_R1: begin
              if (!spi_dout[7]) begin
                r1_d    = spi_dout;
                try_d   = '0;
                state_d = (data_q && spi_dout == 8'h00) ? S_TOKEN : S_CSHI;
              end else if (try_q == TW'(R1_TRIES - 1)) begin
                r1_d = spi_dout; tmo_d = 1'b1; state_d = S_CSHI;
              end
            end
            S_TOKEN: begin
              if (spi_dout == 8'hFE) begin
                state_d = S_DATA;
              end else if (spi_dout[7:4] == 4'h0) begin
                tok_d = 1'b1; state_d = S_CSHI;
              end else if (try_q == TW'(TOKEN_TRIES - 1)) begin
                tmo_d = 1'b1; state_d = S_CSHI;
              end
            end
            S_DATA: begin
              dv_d = 1'b1; dbyte_d = spi_dout; try_d = '0;
              if (daddr_q == 9'd511) state_d = S_CRC;
            end
            S_CRC:   if (try_q != '0) state_d = S_CSHI;
            S_CSHI:  state_d = S_FLUSH;
            S_FLUSH: state_d = S_DONE;
            default: ;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_INIT; cnt_q <= '0; try_q <= '0; wait_q <= 1'b0;
      idx_q <= '0; arg_q <= '0; crc7_q <= '0; data_q <= 1'b0;
      r1_q <= 8'hFF; tmo_q <= 1'b0; tok_q <= 1'b0;
      dv_q <= 1'b0; daddr_q <= '0; dbyte_q <= '0;
      en_q <= 1'b0; rnw_q <= 1'b1; addr_q <= '0; din_q <= 8'hFF;
    end else begin
      state_q <= state_d; cnt_q <= cnt_d; try_q <= try_d; wait_q <= wait_d;
      idx_q <= idx_d; arg_q <= arg_d; crc7_q <= crc7_d; data_q <= data_d;
      r1_q <= r1_d; tmo_q <= tmo_d; tok_q <= tok_d;
      dv_q <= dv_d; daddr_q <= daddr_d; dbyte_q <= dbyte_d;
      en_q <= en_d; rnw_q <= rnw_d; addr_q <= addr_d; din_q <= din_d;
    end
  end

`ifdef SD_CRC16_CHECK_EN
  logic [15:0] crc_q;
  logic [7:0]  crc_hi_q;
  logic        crc_bad_q, crc_err_q;

  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c;
    for (int i = 7; i >= 0; i--) r = {r[14:0], 1'b0} ^ ((r[15] ^ b[i]) ? 16'h1021 : 16'h0000);
    return r;
  endfunction

  // Mismatch is held pending through CSHI/FLUSH and only surfaces with the done pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      crc_q <= '0; crc_hi_q <= '0; crc_bad_q <= 1'b0; crc_err_q <= 1'b0;
    end else begin
      if (state_q == S_IDLE && cmd_start) begin
        crc_q <= '0; crc_bad_q <= 1'b0; crc_err_q <= 1'b0;
      end
      if (op_done && state_q == S_DATA) crc_q <= crc16_byte(crc_q, spi_dout);
      if (op_done && state_q == S_CRC) begin
        if (try_q == '0) crc_hi_q <= spi_dout;
        else             crc_bad_q <= ({crc_hi_q, spi_dout} != crc_q);
      end
      if (state_q == S_FLUSH && state_d == S_DONE && crc_bad_q) crc_err_q <= 1'b1;
    end
  end
  assign crc_err = crc_err_q;
`else
  assign crc_err = 1'b0;
`endif

  assign busy        = !(state_q == S_IDLE || state_q == S_DONE);
  assign done        = (state_q == S_DONE);
  assign r1          = r1_q;
  assign err_timeout = tmo_q;
  assign err_token   = tok_q;
  assign data_valid  = dv_q;
  assign data_addr   = daddr_q;
  assign data_byte   = dbyte_q;
  assign spi_enable  = en_q;
  assign spi_rnw     = rnw_q;
  assign spi_addr    = addr_q;
  assign spi_din     = din_q;
endmodule

// File: tb/tb_sd_cmd_seq.sv
// Randomized self-checking bench for sd_cmd_seq with an SD-card/SPI-master response model.
module tb_sd_cmd_seq;
  localparam int XFER_WAIT = 18;
  localparam int INIT_WAIT = 22600;

  logic        clk = 1'b0, reset_n = 1'b0, cmd_start = 1'b0, cmd_data = 1'b0;
  logic [5:0]  cmd_index = '0;
  logic [31:0] cmd_arg = '0;
  logic [6:0]  cmd_crc = '0;
  logic        busy, done, err_timeout, err_token, crc_err, data_valid;
  logic [7:0]  r1, data_byte, spi_din;
  logic [8:0]  data_addr;
  logic        spi_enable, spi_rnw;
  logic [2:0]  spi_addr;
  logic [7:0]  spi_dout = 8'hFF;

  int n_chk = 0, n_pass = 0, cyc = 0;
  int done_cnt = 0, gap_bad = 0, rnw_bad = 0, last_st = -1000, junk = 0;
  bit last_cs = 1'b0;
  logic       crc_at_done = 1'b0;
  logic [7:0] resp_val = 8'hFF;
  logic [7:0] resp_q[$];
  logic [7:0] mq[$];
  logic [10:0] st_q[$];
  logic [16:0] dv_q[$];

  sd_cmd_seq dut (
    .clk(clk), .reset_n(reset_n), .cmd_start(cmd_start), .cmd_index(cmd_index),
    .cmd_arg(cmd_arg), .cmd_crc(cmd_crc), .cmd_data(cmd_data), .busy(busy), .done(done),
    .r1(r1), .err_timeout(err_timeout), .err_token(err_token), .crc_err(crc_err),
    .data_valid(data_valid), .data_addr(data_addr), .data_byte(data_byte),
    .spi_enable(spi_enable), .spi_rnw(spi_rnw), .spi_addr(spi_addr), .spi_din(spi_din),
    .spi_dout(spi_dout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d required < 150000", cyc);
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // SPI master + card: the real received byte only appears XFER_WAIT cycles after the strobe.
  always @(negedge clk) begin
    if (spi_enable) begin
      st_q.push_back({spi_addr, (spi_addr == 3'd0) ? spi_din : 8'h00});
      if (spi_rnw) rnw_bad++;
      if (cyc - last_st < (last_cs ? 3 : XFER_WAIT + 1)) gap_bad++;
      last_st = cyc;
      last_cs = (spi_addr == 3'd3) || (spi_addr == 3'd4);
      if (spi_addr == 3'd1 || spi_addr == 3'd0) begin
        if (spi_addr == 3'd1 && resp_q.size() > 0) resp_val = resp_q.pop_front();
        else resp_val = 8'hFF;
        junk = XFER_WAIT;
        spi_dout = 8'($urandom);
      end
    end else if (junk > 0) begin
      junk--;
      if (junk == 0) spi_dout = resp_val;
    end
    if (data_valid) dv_q.push_back({data_addr, data_byte});
    if (done) begin
      done_cnt++;
      crc_at_done = crc_err;
    end
  end

  task automatic nxt(output logic [7:0] v);
    if (mq.size() > 0) v = mq.pop_front();
    else v = 8'hFF;
  endtask

  // CRC16-CCITT as the remainder of message*x^16 divided by the generator polynomial.
  function automatic logic [15:0] crc_ref(input logic [7:0] d[$]);
    logic [15:0] r;
    logic top;
    r = '0;
    for (int i = 0; i < d.size() + 2; i++)
      for (int b = 7; b >= 0; b--) begin
        top = r[15];
        r = {r[14:0], (i < d.size()) ? d[i][b] : 1'b0};
        if (top) r = r ^ 16'h1021;
      end
    return r;
  endfunction

  task automatic check_reset(input string tag);
    chk({tag, " reset_vals"},
        {busy, done, r1, err_timeout, err_token, crc_err, data_valid, data_addr, data_byte,
         spi_enable, spi_rnw, spi_addr, spi_din},
        {1'b1, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 9'd0, 8'd0, 1'b0, 1'b1, 3'd0, 8'hFF});
  endtask

  task automatic init_wait(input string tag, input bit poke);
    int nb;
    nb = 0;
    st_q.delete();
    for (int i = 1; i <= INIT_WAIT; i++) begin
      @(posedge clk); #1;
      cmd_start = poke && (i == 100);
      if (busy) nb++;
    end
    cmd_start = 1'b0;
    chk({tag, " busy_cycles"}, nb, INIT_WAIT - 1);
    chk({tag, " busy_after_init"}, busy, 0);
    chk({tag, " no_strobe_in_init"}, st_q.size(), 0);
  endtask

  task automatic run_txn(input string tag, input logic [5:0] idx, input logic [31:0] arg,
                         input logic [6:0] crc, input logic dat);
    logic [10:0] exp_st[$];
    logic [7:0]  dexp[$];
    logic [7:0]  frame[6];
    logic [7:0]  v, c1, c2, r1e;
    bit found, got, to, tk, bad, exp_crc;
    mq = resp_q;
    r1e = 8'hFF; found = 0; got = 0; tk = 0; bad = 0;
    frame = '{{2'b01, idx}, arg[31:24], arg[23:16], arg[15:8], arg[7:0], {crc, 1'b1}};
    exp_st.push_back({3'd4, 8'h00});
    foreach (frame[i]) exp_st.push_back({3'd0, frame[i]});
    for (int k = 0; k < 8 && !found; k++) begin
      nxt(v); exp_st.push_back(11'h100); r1e = v; found = !v[7];
    end
    to = !found;
    if (dat && found && r1e == 8'h00) begin
      for (int k = 0; k < 4096 && !got && !tk; k++) begin
        nxt(v); exp_st.push_back(11'h100);
        got = (v == 8'hFE);
        tk  = !got && (v[7:4] == 4'h0);
      end
      to = !got && !tk;
      if (got) begin
        for (int k = 0; k < 512; k++) begin nxt(v); exp_st.push_back(11'h100); dexp.push_back(v); end
        nxt(c1); nxt(c2);
        exp_st.push_back(11'h100); exp_st.push_back(11'h100);
        bad = ({c1, c2} != crc_ref(dexp));
      end
    end
    exp_st.push_back({3'd3, 8'h00});
    exp_st.push_back(11'h100);
`ifdef SD_CRC16_CHECK_EN
    exp_crc = bad;
`else
    exp_crc = 1'b0;
`endif

    st_q.delete(); dv_q.delete(); done_cnt = 0;
    @(posedge clk); #1;
    cmd_index = idx; cmd_arg = arg; cmd_crc = crc; cmd_data = dat; cmd_start = 1'b1;
    @(posedge clk); #1;
    cmd_start = 1'b0; cmd_index = ~idx; cmd_arg = ~arg; cmd_crc = ~crc; cmd_data = ~dat;
    chk({tag, " busy_start"}, busy, 1);
    repeat (50) @(posedge clk);
    #1 cmd_start = 1'b1;
    @(posedge clk); #1 cmd_start = 1'b0;
    for (int i = 0; i < 20000 && done_cnt == 0; i++) @(posedge clk);
    repeat (3) @(posedge clk); #1;

    chk({tag, " done_pulses"}, done_cnt, 1);
    chk({tag, " busy_end"}, busy, 0);
    chk({tag, " n_strobes"}, st_q.size(), exp_st.size());
    for (int i = 0; i < exp_st.size() && i < st_q.size(); i++) chk({tag, " strobe"}, st_q[i], exp_st[i]);
    chk({tag, " r1"}, r1, r1e);
    chk({tag, " err_timeout"}, err_timeout, to);
    chk({tag, " err_token"}, err_token, tk);
    chk({tag, " crc_err_at_done"}, crc_at_done, exp_crc);
    chk({tag, " crc_err_held"}, crc_err, exp_crc);
    chk({tag, " n_data"}, dv_q.size(), dexp.size());
    for (int i = 0; i < dexp.size() && i < dv_q.size(); i++) chk({tag, " data"}, dv_q[i], {9'(i), dexp[i]});
    chk({tag, " strobe_spacing_violations"}, gap_bad, 0);
    chk({tag, " rnw_during_enable"}, rnw_bad, 0);
  endtask

  initial begin
    logic [7:0]  blk[$];
    logic [15:0] c;
    int n_before;
    reset_n = 1'b0;
    repeat (3) @(posedge clk); #1;
    check_reset("por");
    @(negedge clk) reset_n = 1'b1;
    init_wait("por", 1'b1);

    resp_q = '{8'hFF, 8'hFF, 8'h01};
    run_txn("cmd0", 6'd0, 32'h0, 7'h4A, 1'b0);

    resp_q.delete();
    run_txn("r1_timeout", 6'd8, 32'h1AA, 7'h43, 1'b0);

    blk.delete();
    for (int i = 0; i < 512; i++) blk.push_back(8'(i));
    c = crc_ref(blk);
    resp_q = '{8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFE};
    foreach (blk[i]) resp_q.push_back(blk[i]);
    resp_q.push_back(c[15:8]); resp_q.push_back(c[7:0]);
    run_txn("cmd17", 6'd17, 32'h0000_1234, 7'h55, 1'b1);

    resp_q = '{8'h00, 8'h09};
    run_txn("err_token", 6'd17, 32'h0000_0200, 7'h11, 1'b1);

    for (int t = 0; t < 6; t++) begin
      logic [7:0] rv;
      resp_q.delete();
      repeat ($urandom_range(0, 9)) resp_q.push_back(8'hFF);
      rv = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(1, 127));
      resp_q.push_back(rv);
      repeat ($urandom_range(0, 5)) resp_q.push_back(8'hFF);
      resp_q.push_back(8'($urandom_range(0, 15)));
      run_txn("random", 6'($urandom), $urandom, 7'($urandom), 1'($urandom_range(0, 1)));
    end

    blk.delete();
    for (int i = 0; i < 512; i++) blk.push_back(8'($urandom));
    c = crc_ref(blk) ^ 16'h0004;
    resp_q = '{8'h00, 8'hFE};
    foreach (blk[i]) resp_q.push_back(blk[i]);
    resp_q.push_back(c[15:8]); resp_q.push_back(c[7:0]);
    run_txn("crc_corrupt", 6'd17, 32'h0000_0800, 7'h2B, 1'b1);

    resp_q.delete(); st_q.delete();
    @(posedge clk); #1;
    cmd_index = 6'd17; cmd_data = 1'b1; cmd_start = 1'b1;
    @(posedge clk); #1 cmd_start = 1'b0;
    for (int i = 0; i < 2000 && st_q.size() < 4; i++) @(posedge clk);
    #1 reset_n = 1'b0;
    #1 check_reset("mid_reset");
    n_before = st_q.size();
    repeat (20) @(posedge clk);
    chk("mid_reset no_strobe_after_abort", st_q.size(), n_before);
    @(negedge clk) reset_n = 1'b1;
    init_wait("post_abort", 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/sd_cmd_seq.md
Name: sd_cmd_seq

Overview:
- Sequencer that drives the byte-level SPI master's register strobe interface (enable/rnw/addr/din/dout) to run complete SD-card SPI-mode transactions without CPU byte banging.
- One transaction: assert CS, send a 6-byte command frame, poll for R1, optionally read a 512-byte data block, release CS, then send one flush byte.
- Sits between a host control register and the SPI master; the host sees start/busy/done plus a byte-write port into a sector buffer.

Parameters:
- XFER_WAIT, 18, cycles waited after each SPI strobe before sampling spi_dout; the master needs ≥16.
- INIT_WAIT, 22600, cycles after reset release before the first transaction; covers the master's power-up clocking.
- R1_TRIES, 8, maximum 0xFF polls for an R1 response.
- TOKEN_TRIES, 4096, maximum 0xFF polls for the data start token.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- cmd_start  in  1  one-cycle request; accepted only when busy=0
- cmd_index  in  6  SD command number
- cmd_arg  in  32  command argument, MSB first on the wire
- cmd_crc  in  7  CRC7; sent as {cmd_crc,1'b1}
- cmd_data  in  1  1 = read a data block after R1
- busy  out  1  sequencer active or in init wait
- done  out  1  one-cycle pulse at end of transaction
- r1  out  8  last R1 received
- err_timeout  out  1  R1 or token timeout; held until the next accepted start
- err_token  out  1  data error token received; held until the next accepted start
- crc_err  out  1  see Optional Feature
- data_valid  out  1  one-cycle strobe per data byte
- data_addr  out  9  byte index 0..511
- data_byte  out  8  received data byte
- spi_enable  out  1  one-cycle strobe to the SPI master
- spi_rnw  out  1  always 0 when spi_enable=1
- spi_addr  out  3  0 = write din, 1 = write 0xFF, 3 = CS high, 4 = CS low
- spi_din  out  8  byte for spi_addr=0
- spi_dout  in  8  last received byte from the SPI master

Behaviour:
- Reset values: busy=1, done=0, r1=0xFF, all error flags 0, data_valid=0, data_addr=0, data_byte=0, spi_enable=0, spi_rnw=1, spi_addr=0, spi_din=0xFF. State is INIT.
- Reset asserted mid-transaction aborts immediately to the reset values. No CS-high strobe is issued; the SPI master has its own reset.
- Byte operation: one strobe cycle (spi_enable=1), then an XFER_WAIT-cycle counter. spi_dout is sampled in the cycle the counter reaches XFER_WAIT, and the next strobe is no earlier than the following cycle.
- CS operations (addr 3/4) take one strobe cycle plus 2 idle cycles.
- INIT: count INIT_WAIT cycles, then go to IDLE with busy=0.
- IDLE: on cmd_start, latch all cmd_* inputs, clear the error flags, set busy=1, go to CSLO. cmd_start while busy=1 is ignored.
- CSLO: strobe addr 4, then go to SEND.
- SEND: 6 bytes via addr 0: {01,cmd_index}, arg[31:24], arg[23:16], arg[15:8], arg[7:0], {cmd_crc,1}.
- POLL_R1: addr-1 byte operations. The first sample with bit7=0 is latched to r1.
  - If cmd_data=1 and r1=0x00, go to TOKEN; otherwise go to CSHI.
  - After R1_TRIES samples with bit7=1: r1=last sample (0xFF), err_timeout=1, go to CSHI.
- TOKEN: addr-1 polls.
  - 0xFE: go to DATA.
  - Any value with bits[7:4]=0: err_token=1, go to CSHI.
  - TOKEN_TRIES polls returning 0xFF: err_timeout=1, go to CSHI.
- DATA: 512 addr-1 reads. Each sample produces data_valid for one cycle with data_byte=sample and data_addr=index (0..511). data_addr wraps to 0 at the end of the block.
- CRC: 2 addr-1 reads, then go to CSHI.
- CSHI: strobe addr 3, then go to FLUSH.
- FLUSH: one addr-1 byte (8 clocks with CS high), then go to DONE.
- DONE: done=1 for one cycle, busy=0, return to IDLE.
- Error paths always pass through CSHI and FLUSH before DONE.

Optional Feature:
- Macro SD_CRC16_CHECK_EN.
- Defined: CRC16-CCITT (poly 0x1021, init 0x0000) is computed over the 512 data bytes, byte-serial with an 8-step unrolled update per byte. It is compared with the 2 received CRC bytes (MSB first). On mismatch, crc_err=1 in the DONE cycle, held until the next accepted start.
- Not defined: CRC bytes are read and discarded, and crc_err is constant 0.

Test Plan:
- Reset release: busy=1 for 22600 cycles; cmd_start at cycle 100 is ignored (no spi_enable). busy=0 afterwards.
- CMD0, arg 0, crc 0x4A; slave returns FF,FF,01 → strobes addr4, then addr0 bytes 40 00 00 00 00 95, then 3 addr1 polls, addr3, addr1. Result: r1=0x01, done pulse, no errors.
- R1 timeout: slave always returns 0xFF → exactly 8 polls, err_timeout=1, r1=0xFF, CS released, done pulse.
- CMD17 with cmd_data=1; r1=00, token after 3×FF, data byte i = i mod 256 → 512 data_valid pulses with data_addr 0..511 and correct bytes, then 2 CRC reads and done.
- Error token 0x09 in TOKEN → err_token=1, no data_valid, addr3 strobe, done.
- SD_CRC16_CHECK_EN defined: correct CRC → crc_err=0; flip one CRC bit → crc_err=1. Macro undefined, same corrupt CRC → crc_err=0.
